// File: rtl/des_round_ctrl.sv
// ---------------------------------------------------------------------------
// des_round_ctrl
//
// Sequencer for an iterative, one-round-per-cycle DES datapath. A block is
// processed as: load IP(data)/PC1(key), sixteen Feistel rounds, capture of
// FP(R16,L16), then a result-valid phase held until the consumer takes it
// (or a single-cycle pulse when AUTO_ACK=1). Start to out_valid is 19 cycles.
//
// Parameters
//   AUTO_ACK   1 = out_valid is a one-cycle pulse and out_ack is ignored
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset, returns to IDLE at once
//   start      in   block request, accepted only while ready=1
//   decrypt    in   mode sampled on acceptance (0 encrypt, 1 decrypt)
//   out_ack    in   consumer accepts the result while out_valid=1
//   ready      out  controller idle, a start will be accepted
//   ld_init    out  one-cycle strobe: load IP(data_in) and PC1(key_in)
//   rnd_en     out  execute one Feistel round this cycle
//   round      out  current round index 0..15 (0 outside the round phase)
//   key_shift  out  C/D rotate amount for this round
//   key_dir    out  rotate direction, 0 = left, 1 = right
//   ld_out     out  one-cycle strobe: capture FP(R16,L16)
//   out_valid  out  result available in the datapath output register
//   busy       out  controller is working on, or holding, a block
// ---------------------------------------------------------------------------
module des_round_ctrl #(
    parameter bit AUTO_ACK = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       decrypt,
    input  logic       out_ack,
    output logic       ready,
    output logic       ld_init,
    output logic       rnd_en,
    output logic [3:0] round,
    output logic [1:0] key_shift,
    output logic       key_dir,
    output logic       ld_out,
    output logic       out_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       mode_q,  mode_d;

    // State, round counter and mode registers. Reset parks the counter at
    // its saturated value so it only ever counts inside a block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            round_q <= 4'd15;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic. The mode is captured only on acceptance in IDLE so
    // a toggling decrypt input cannot disturb a block in flight.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                round_d = 4'd15;
                if (start) begin
                    state_d = LOAD;
                    mode_d  = decrypt;
                end
            end
            LOAD: begin
                state_d = ROUND;
                round_d = 4'd0;
            end
            ROUND: begin
                if (round_q == 4'd15) begin
                    state_d = FINAL;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            FINAL: begin
                state_d = DONE;
                round_d = 4'd15;
            end
            DONE: begin
                round_d = 4'd15;
                if (AUTO_ACK || out_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                round_d = 4'd15;
            end
        endcase
    end

    // Output decode. Each datapath strobe belongs to exactly one state, so
    // they are mutually exclusive by construction. The key schedule uses
    // single rotates in rounds 1, 8 and 15 in both directions; round 0 is a
    // single left rotate when encrypting, but when decrypting the key after
    // PC1 already equals the fully rotated K16 key, so no rotate is needed.
    always_comb begin
        ready     = 1'b0;
        ld_init   = 1'b0;
        rnd_en    = 1'b0;
        round     = 4'd0;
        key_shift = 2'd0;
        key_dir   = 1'b0;
        ld_out    = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
            LOAD: begin
                ld_init = 1'b1;
            end
            ROUND: begin
                rnd_en  = 1'b1;
                round   = round_q;
                key_dir = mode_q;
                if (round_q == 4'd0) begin
                    key_shift = mode_q ? 2'd0 : 2'd1;
                end else if (round_q == 4'd1 || round_q == 4'd8 ||
                             round_q == 4'd15) begin
                    key_shift = 2'd1;
                end else begin
                    key_shift = 2'd2;
                end
            end
            FINAL: begin
                ld_out = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
        endcase
    end

endmodule
